mul_seq: RTL and testbench

- Multi-cycle shift-add multiplier controller; produces the low 32 bits of a 32x32 product.
- Sequences the shared 32-bit add/subtract unit one bit per cycle.
- Arbitrates that adder between the ALU and the sequencer: the ALU path passes through when idle; the sequencer owns the adder while RUN.
- Sits beside the ALU in the execute stage; the core stalls on busy.

---
 rtl/mul_seq.sv | 101 ++++++++++
 tb/tb_mul_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - shift-add sequential multiplier sharing the ALU adder
module mul_seq #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic             alu_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_next;
  logic             last_step;

  // The final RUN step may still add, so DONE captures the post-add value.
  always_comb begin
    acc_next  = mp[0] ? add_sum : acc;
    last_step = (count == LAST) || (EARLY_EXIT && (mp[WIDTH-1:1] == '0));
  end

  always_comb begin
    add_a   = alu_a;
    add_b   = alu_b;
    add_cin = alu_cin;
    if (state == RUN) begin
      add_a   = acc;
      add_b   = mc;
      add_cin = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      mc     <= '0;
      mp     <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mc    <= mcand;
            mp    <= mplier;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          mc    <= mc << 1;
          mp    <= mp >> 1;
          count <= count + 1'b1;
          if (last_step) begin
            result <= acc_next;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed bench for mul_seq, early-exit and full-length variants
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] mcand, mplier;
  logic [31:0] alu_a, alu_b;
  logic        alu_cin;

  logic        busy0, done0, add_cin0;
  logic [31:0] result0, add_a0, add_b0, add_sum0;
  logic        busy1, done1, add_cin1;
  logic [31:0] result1, add_a1, add_b1, add_sum1;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign add_sum0 = add_a0 + add_b0 + 32'(add_cin0);
  assign add_sum1 = add_a1 + add_b1 + 32'(add_cin1);

  mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy0), .done(done0), .result(result0),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .add_a(add_a0), .add_b(add_b0), .add_cin(add_cin0), .add_sum(add_sum0)
  );

  mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy1), .done(done1), .result(result1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_sum(add_sum1)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    int          lat_ee;
  } vec_t;

  vec_t vecs[9];

  int lat0, lat1, pulses0, pulses1, busyc0, both, mux_err;
  logic [31:0] r0, r1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    lat0 = 0; lat1 = 0; pulses0 = 0; pulses1 = 0; busyc0 = 0; both = 0; mux_err = 0;
    r0 = 'x; r1 = 'x;
  endtask

  task automatic sample(input int cyc);
    if (busy0 && done0) both++;
    if (busy1 && done1) both++;
    if (busy0) busyc0++;
    if (done0) begin
      pulses0++;
      if (lat0 == 0) begin lat0 = cyc; r0 = result0; end
    end
    if (done1) begin
      pulses1++;
      if (lat1 == 0) begin lat1 = cyc; r1 = result1; end
    end
    if (busy0) begin
      if (add_cin0 !== 1'b0) mux_err++;
    end else if (add_a0 !== alu_a || add_b0 !== alu_b || add_cin0 !== alu_cin) mux_err++;
    if (busy1) begin
      if (add_cin1 !== 1'b0) mux_err++;
    end else if (add_a1 !== alu_a || add_b1 !== alu_b || add_cin1 !== alu_cin) mux_err++;
  endtask

  task automatic idle_cycles(input int first, input int n);
    for (int c = first; c < first + n; c++) begin
      @(negedge clk);
      alu_a = $urandom; alu_b = $urandom; alu_cin = 1'($urandom);
      #1 sample(c);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    clear_stats();
    @(negedge clk);
    mcand = v.a; mplier = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 sample(0);
    idle_cycles(1, 40);
    chk({tag, " ee_latency"}, 32'(lat0), 32'(v.lat_ee));
    chk({tag, " full_latency"}, 32'(lat1), 32'd32);
    chk({tag, " ee_result_at_done"}, r0, v.prod);
    chk({tag, " full_result_at_done"}, r1, v.prod);
    chk({tag, " ee_result_held"}, result0, v.prod);
    chk({tag, " ee_done_pulses"}, 32'(pulses0), 32'd1);
    chk({tag, " full_done_pulses"}, 32'(pulses1), 32'd1);
    chk({tag, " ee_busy_cycles"}, 32'(busyc0), 32'(v.lat_ee));
    chk({tag, " busy_and_done"}, 32'(both), 32'd0);
    chk({tag, " adder_mux"}, 32'(mux_err), 32'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{a: 32'd3,          b: 32'd5,          prod: 32'd15,         lat_ee: 3};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   prod: 32'h00000001,   lat_ee: 32};
    vecs[2] = '{a: 32'h00010000,   b: 32'h00010000,   prod: 32'h00000000,   lat_ee: 17};
    vecs[3] = '{a: 32'd1234,       b: 32'd0,          prod: 32'd0,          lat_ee: 1};
    vecs[4] = '{a: 32'd7,          b: 32'd9,          prod: 32'd63,         lat_ee: 4};
    vecs[5] = '{a: 32'h12345678,   b: 32'd1,          prod: 32'h12345678,   lat_ee: 1};
    vecs[6] = '{a: 32'hFFFFFFFF,   b: 32'd2,          prod: 32'hFFFFFFFE,   lat_ee: 2};
    vecs[7] = '{a: 32'h80000000,   b: 32'h80000000,   prod: 32'h00000000,   lat_ee: 32};
    vecs[8] = '{a: 32'd100,        b: 32'd100,        prod: 32'd10000,      lat_ee: 7};

    reset = 1'b1; start = 1'b1; mcand = 32'd3; mplier = 32'd5;
    alu_a = 32'h12345678; alu_b = 32'h00000001; alu_cin = 1'b1;
    repeat (3) @(negedge clk);
    // start held with reset must not launch an operation
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_done", 32'(done0), 32'd0);
    chk("reset_result", result0, 32'd0);
    chk("reset_full_busy", 32'(busy1), 32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy0), 32'd0);
    chk("idle_add_a", add_a0, 32'h12345678);
    chk("idle_add_b", add_b0, 32'h00000001);
    chk("idle_add_cin", 32'(add_cin0), 32'd1);

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      run_op(v, $sformatf("vec%0d", i));
    end

    // start re-pulsed during RUN with new operands is ignored
    clear_stats();
    @(negedge clk);
    mcand = 32'd3; mplier = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 sample(0);
    @(negedge clk);
    mcand = 32'd7; mplier = 32'd9; start = 1'b1;
    #1 sample(1);
    @(negedge clk);
    start = 1'b0;
    #1 sample(2);
    idle_cycles(3, 40);
    chk("repulse_ee_result", result0, 32'd15);
    chk("repulse_full_result", result1, 32'd15);
    chk("repulse_ee_pulses", 32'(pulses0), 32'd1);
    chk("repulse_full_pulses", 32'(pulses1), 32'd1);
    chk("repulse_ee_latency", 32'(lat0), 32'd3);
    v = '{a: 32'd7, b: 32'd9, prod: 32'd63, lat_ee: 4};
    run_op(v, "fresh_after_repulse");

    // reset in the middle of a run aborts it
    @(negedge clk);
    mcand = 32'd6; mplier = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 32'(busy0), 32'd1);
    reset = 1'b1;
    alu_a = 32'hCAFEF00D; alu_b = 32'h0000BEEF; alu_cin = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_result", result0, 32'd0);
    chk("abort_add_a", add_a0, 32'hCAFEF00D);
    chk("abort_add_b", add_b0, 32'h0000BEEF);
    chk("abort_full_busy", 32'(busy1), 32'd0);
    clear_stats();
    idle_cycles(1, 40);
    chk("abort_no_ee_done", 32'(pulses0), 32'd0);
    chk("abort_no_full_done", 32'(pulses1), 32'd0);
    v = '{a: 32'd6, b: 32'd7, prod: 32'd42, lat_ee: 3};
    run_op(v, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
